// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the MIPS boot/run controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Default memory word width of the 5-stage core
  localparam int DATA_W_DEFAULT = 32;

  // Controller phases: stream image, hold core in reset, run, finished
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Load-stream target select
  localparam logic TGT_IM = 1'b0;
  localparam logic TGT_DM = 1'b1;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/boot_addr_ctr.sv
`default_nettype none
// ============================================================================
// Module      : boot_addr_ctr
// Description : Non-wrapping write pointer for one memory. Once index
//               DEPTH-1 has been written the pointer parks there, further
//               requests are refused and flagged as overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_addr_ctr #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_req,
  output logic          o_wr,
  output logic [AW-1:0] o_ptr,
  output logic          o_full,
  output logic          o_ovf
);

  localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

  logic [AW-1:0] r_ptr;
  logic          r_full;

  assign o_wr   = i_req & ~r_full;
  assign o_ovf  = i_req & r_full;
  assign o_ptr  = r_ptr;
  assign o_full = r_full;

  // Advance the pointer after each granted write; stop at the last index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_full <= 1'b0;
    end else if (i_clear) begin
      r_ptr  <= '0;
      r_full <= 1'b0;
    end else if (o_wr) begin
      if (r_ptr == C_LAST) begin
        r_full <= 1'b1;
      end else begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

endmodule : boot_addr_ctr
`default_nettype wire

// File: rtl/cpu_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_boot_ctrl
// Description : Boot/run controller for the 5-stage MIPS core. Streams an
//               image into IM/DM, holds the core in reset, releases it,
//               counts run cycles and stops on halt or cycle budget.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_boot_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int IM_DEPTH   = 64,
  parameter int DM_DEPTH   = 128,
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_clear,
  input  logic                        i_ld_valid,
  output logic                        o_ld_ready,
  input  logic                        i_ld_target,
  input  logic                        i_ld_last,
  input  logic [DATA_W-1:0]           i_ld_data,
  input  logic                        i_start,
  input  logic [CNT_W-1:0]            i_cycle_limit,
  input  logic                        i_halt_req,
  output logic                        o_im_we,
  output logic [$clog2(IM_DEPTH)-1:0] o_im_addr,
  output logic                        o_dm_we,
  output logic [$clog2(DM_DEPTH)-1:0] o_dm_addr,
  output logic [DATA_W-1:0]           o_wdata,
  output logic                        o_core_rst,
  output logic                        o_core_en,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_timeout,
  output logic                        o_ld_err,
  output logic [CNT_W-1:0]            o_cycles
);

  localparam int IM_AW = $clog2(IM_DEPTH);
  localparam int DM_AW = $clog2(DM_DEPTH);
  localparam int HW    = $clog2(RST_CYCLES + 1);
  localparam logic [HW-1:0] C_HOLD_LAST = HW'(RST_CYCLES - 1);

  state_e             r_state;
  logic [HW-1:0]      r_hold_cnt;
  logic [CNT_W-1:0]   r_cycles;
  logic               r_core_rst;
  logic               r_core_en;
  logic               r_busy;
  logic               r_done;
  logic               r_timeout;
  logic               r_im_we;
  logic [IM_AW-1:0]   r_im_addr;
  logic               r_dm_we;
  logic [DM_AW-1:0]   r_dm_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_ld_err;

  logic               w_accept;
  logic               w_im_req;
  logic               w_dm_req;
  logic               w_im_wr;
  logic               w_dm_wr;
  logic               w_im_ovf;
  logic               w_dm_ovf;
  logic               w_im_full;
  logic               w_dm_full;
  logic [IM_AW-1:0]   w_im_ptr;
  logic [DM_AW-1:0]   w_dm_ptr;
  logic [CNT_W:0]     w_cycles_inc;
  logic               w_limit_hit;

  // A beat is taken whenever we are loading; clear discards it
  assign o_ld_ready = (r_state == ST_LOAD);
  assign w_accept   = i_ld_valid & o_ld_ready;
  assign w_im_req   = w_accept & (i_ld_target == TGT_IM) & ~i_clear;
  assign w_dm_req   = w_accept & (i_ld_target == TGT_DM) & ~i_clear;

  // Budget check uses one extra bit so a saturated counter never matches
  assign w_cycles_inc = {1'b0, r_cycles} + (CNT_W + 1)'(1);
  assign w_limit_hit  = (i_cycle_limit != '0) &&
                        (w_cycles_inc == {1'b0, i_cycle_limit});

  boot_addr_ctr #(
    .DEPTH (IM_DEPTH),
    .AW    (IM_AW)
  ) u_im_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (i_clear),
    .i_req   (w_im_req),
    .o_wr    (w_im_wr),
    .o_ptr   (w_im_ptr),
    .o_full  (w_im_full),
    .o_ovf   (w_im_ovf)
  );

  boot_addr_ctr #(
    .DEPTH (DM_DEPTH),
    .AW    (DM_AW)
  ) u_dm_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (i_clear),
    .i_req   (w_dm_req),
    .o_wr    (w_dm_wr),
    .o_ptr   (w_dm_ptr),
    .o_full  (w_dm_full),
    .o_ovf   (w_dm_ovf)
  );

  // Registered memory write port: one strobe per granted beat, one cycle late
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_im_we   <= 1'b0;
      r_im_addr <= '0;
      r_dm_we   <= 1'b0;
      r_dm_addr <= '0;
      r_wdata   <= '0;
      r_ld_err  <= 1'b0;
    end else if (i_clear) begin
      r_im_we   <= 1'b0;
      r_im_addr <= '0;
      r_dm_we   <= 1'b0;
      r_dm_addr <= '0;
      r_wdata   <= '0;
      r_ld_err  <= 1'b0;
    end else begin
      r_im_we <= w_im_wr;
      r_dm_we <= w_dm_wr;
      if (w_im_wr) begin
        r_im_addr <= w_im_ptr;
      end
      if (w_dm_wr) begin
        r_dm_addr <= w_dm_ptr;
      end
      if (w_im_wr || w_dm_wr) begin
        r_wdata <= i_ld_data;
      end
      if (w_im_ovf || w_dm_ovf) begin
        r_ld_err <= 1'b1;
      end
    end
  end

  // Boot sequencer with registered core controls and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_LOAD;
      r_hold_cnt <= '0;
      r_cycles   <= '0;
      r_core_rst <= 1'b1;
      r_core_en  <= 1'b0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (i_clear) begin
      r_state    <= ST_LOAD;
      r_hold_cnt <= '0;
      r_cycles   <= '0;
      r_core_rst <= 1'b1;
      r_core_en  <= 1'b0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if ((w_accept && i_ld_last) || i_start) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == C_HOLD_LAST) begin
            r_state    <= ST_RUN;
            r_core_rst <= 1'b0;
            r_core_en  <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (r_cycles != '1) begin
            r_cycles <= r_cycles + 1'b1;
          end
          if (i_halt_req || w_limit_hit) begin
            r_state   <= ST_DONE;
            r_core_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= ~i_halt_req;
          end
        end
        default: begin
          r_state <= ST_DONE;
        end
      endcase
    end
  end

  assign o_im_we    = r_im_we;
  assign o_im_addr  = r_im_addr;
  assign o_dm_we    = r_dm_we;
  assign o_dm_addr  = r_dm_addr;
  assign o_wdata    = r_wdata;
  assign o_core_rst = r_core_rst;
  assign o_core_en  = r_core_en;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_timeout  = r_timeout;
  assign o_ld_err   = r_ld_err;
  assign o_cycles   = r_cycles;

endmodule : cpu_boot_ctrl
`default_nettype wire

// File: tb/tb_cpu_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_boot_ctrl
// Description : Directed self-checking bench for cpu_boot_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_boot_ctrl;

  localparam int DATA_W     = 32;
  localparam int IM_DEPTH   = 64;
  localparam int DM_DEPTH   = 128;
  localparam int RST_CYCLES = 2;
  localparam int CNT_W      = 32;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic              ld_valid;
  logic              ld_ready;
  logic              ld_target;
  logic              ld_last;
  logic [DATA_W-1:0] ld_data;
  logic              start;
  logic [CNT_W-1:0]  cycle_limit;
  logic              halt_req;
  logic              im_we;
  logic [5:0]        im_addr;
  logic              dm_we;
  logic [6:0]        dm_addr;
  logic [DATA_W-1:0] wdata;
  logic              core_rst;
  logic              core_en;
  logic              busy;
  logic              done;
  logic              timeout;
  logic              ld_err;
  logic [CNT_W-1:0]  cycles;

  int nvec  = 0;
  int nfail = 0;

  cpu_boot_ctrl #(
    .DATA_W     (DATA_W),
    .IM_DEPTH   (IM_DEPTH),
    .DM_DEPTH   (DM_DEPTH),
    .RST_CYCLES (RST_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (clear),
    .i_ld_valid    (ld_valid),
    .o_ld_ready    (ld_ready),
    .i_ld_target   (ld_target),
    .i_ld_last     (ld_last),
    .i_ld_data     (ld_data),
    .i_start       (start),
    .i_cycle_limit (cycle_limit),
    .i_halt_req    (halt_req),
    .o_im_we       (im_we),
    .o_im_addr     (im_addr),
    .o_dm_we       (dm_we),
    .o_dm_addr     (dm_addr),
    .o_wdata       (wdata),
    .o_core_rst    (core_rst),
    .o_core_en     (core_en),
    .o_busy        (busy),
    .o_done        (done),
    .o_timeout     (timeout),
    .o_ld_err      (ld_err),
    .o_cycles      (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic tgt, input logic [DATA_W-1:0] d, input logic last);
    ld_valid  = 1'b1;
    ld_target = tgt;
    ld_data   = d;
    ld_last   = last;
    tick();
  endtask

  task automatic chk_reset(input string ph);
    chk({ph, " im_we"},    64'(im_we),    64'd0);
    chk({ph, " im_addr"},  64'(im_addr),  64'd0);
    chk({ph, " dm_we"},    64'(dm_we),    64'd0);
    chk({ph, " dm_addr"},  64'(dm_addr),  64'd0);
    chk({ph, " wdata"},    64'(wdata),    64'd0);
    chk({ph, " core_rst"}, 64'(core_rst), 64'd1);
    chk({ph, " core_en"},  64'(core_en),  64'd0);
    chk({ph, " busy"},     64'(busy),     64'd1);
    chk({ph, " done"},     64'(done),     64'd0);
    chk({ph, " timeout"},  64'(timeout),  64'd0);
    chk({ph, " ld_err"},   64'(ld_err),   64'd0);
    chk({ph, " cycles"},   64'(cycles),   64'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    rst_n       = 1'b0;
    clear       = 1'b0;
    ld_valid    = 1'b0;
    ld_target   = 1'b0;
    ld_last     = 1'b0;
    ld_data     = '0;
    start       = 1'b0;
    cycle_limit = 32'd60;
    halt_req    = 1'b0;

    // Reset state
    #12;
    chk_reset("rst");
    #10;
    rst_n = 1'b1;
    #1;
    chk("rst ld_ready", 64'(ld_ready), 64'd1);
    tick();

    // Image load: 15 IM words (jump at index 9), 2 DM words, last on DM
    for (int i = 0; i < 15; i++) begin
      d = (i == 9) ? 32'h0800_0001 : (32'h2000_0000 | 32'(i));
      beat(1'b0, d, 1'b0);
      chk($sformatf("im_we[%0d]", i),   64'(im_we),   64'd1);
      chk($sformatf("im_addr[%0d]", i), 64'(im_addr), 64'(i));
      chk($sformatf("wdata[%0d]", i),   64'(wdata),   64'(d));
    end
    beat(1'b1, 32'd9, 1'b0);
    chk("dm0 we",   64'(dm_we),   64'd1);
    chk("dm0 addr", 64'(dm_addr), 64'd0);
    chk("dm0 data", 64'(wdata),   64'd9);
    chk("dm0 imwe", 64'(im_we),   64'd0);
    beat(1'b1, 32'd3, 1'b1);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("dm1 we",       64'(dm_we),    64'd1);
    chk("dm1 addr",     64'(dm_addr),  64'd1);
    chk("dm1 data",     64'(wdata),    64'd3);
    chk("hold1 rst",    64'(core_rst), 64'd1);
    chk("hold1 ready",  64'(ld_ready), 64'd0);
    tick();
    chk("hold2 dm_we",  64'(dm_we),    64'd0);
    chk("hold2 rst",    64'(core_rst), 64'd1);
    chk("hold2 en",     64'(core_en),  64'd0);
    tick();
    chk("run1 rst",     64'(core_rst), 64'd0);
    chk("run1 en",      64'(core_en),  64'd1);
    chk("run1 cycles",  64'(cycles),   64'd0);

    // Cycle limit 60 expires without halt
    repeat (59) tick();
    chk("lim c59",      64'(cycles),   64'd59);
    chk("lim done0",    64'(done),     64'd0);
    tick();
    chk("lim done",     64'(done),     64'd1);
    chk("lim timeout",  64'(timeout),  64'd1);
    chk("lim cycles",   64'(cycles),   64'd60);
    chk("lim en",       64'(core_en),  64'd0);
    chk("lim busy",     64'(busy),     64'd0);
    tick();
    chk("done frozen",  64'(cycles),   64'd60);
    chk("done rst",     64'(core_rst), 64'd0);
    chk("done held",    64'(done),     64'd1);

    // Halt at RUN cycle 25 coincides with limit 25: halt wins
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr done",     64'(done),     64'd0);
    chk("clr cycles",   64'(cycles),   64'd0);
    chk("clr rst",      64'(core_rst), 64'd1);
    chk("clr ready",    64'(ld_ready), 64'd1);
    cycle_limit = 32'd25;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start hold",   64'(ld_ready), 64'd0);
    tick();
    tick();
    chk("h run en",     64'(core_en),  64'd1);
    repeat (24) tick();
    chk("h c24",        64'(cycles),   64'd24);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("h done",       64'(done),     64'd1);
    chk("h timeout",    64'(timeout),  64'd0);
    chk("h cycles",     64'(cycles),   64'd25);

    // Clear in RUN at cycle 10 with a concurrent beat
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cycle_limit = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    repeat (9) tick();
    chk("c10 cycles",   64'(cycles),   64'd9);
    chk("c10 en",       64'(core_en),  64'd1);
    clear     = 1'b1;
    ld_valid  = 1'b1;
    ld_target = 1'b0;
    ld_data   = 32'hDEAD_BEEF;
    tick();
    clear    = 1'b0;
    ld_valid = 1'b0;
    chk("clr10 ready",  64'(ld_ready), 64'd1);
    chk("clr10 cycles", 64'(cycles),   64'd0);
    chk("clr10 rst",    64'(core_rst), 64'd1);
    chk("clr10 en",     64'(core_en),  64'd0);
    chk("clr10 im_we",  64'(im_we),    64'd0);
    tick();
    chk("clr10 nowr",   64'(im_we),    64'd0);

    // IM overflow: 66 beats into 64 words
    for (int i = 0; i < 64; i++) begin
      beat(1'b0, 32'hA000_0000 | 32'(i), 1'b0);
      chk($sformatf("ovf we[%0d]", i),   64'(im_we),   64'd1);
      chk($sformatf("ovf addr[%0d]", i), 64'(im_addr), 64'(i));
    end
    chk("ovf err0",     64'(ld_err),   64'd0);
    beat(1'b0, 32'hA000_0040, 1'b0);
    chk("ovf65 we",     64'(im_we),    64'd0);
    chk("ovf65 addr",   64'(im_addr),  64'd63);
    chk("ovf65 err",    64'(ld_err),   64'd1);
    beat(1'b0, 32'hA000_0041, 1'b0);
    chk("ovf66 we",     64'(im_we),    64'd0);
    chk("ovf66 addr",   64'(im_addr),  64'd63);
    beat(1'b1, 32'h0000_0055, 1'b0);
    ld_valid = 1'b0;
    chk("ovf dm we",    64'(dm_we),    64'd1);
    chk("ovf dm addr",  64'(dm_addr),  64'd0);
    chk("ovf err held", 64'(ld_err),   64'd1);

    // Async reset mid-LOAD after 5 beats, with a sixth beat pending
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr err",      64'(ld_err),   64'd0);
    for (int i = 0; i < 5; i++) begin
      beat(1'b0, 32'hB000_0000 | 32'(i), 1'b0);
    end
    chk("pre addr",     64'(im_addr),  64'd4);
    ld_valid  = 1'b1;
    ld_target = 1'b0;
    ld_data   = 32'hCAFE_F00D;
    ld_last   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("arst");
    #11;
    chk_reset("arst2");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post we",      64'(im_we),    64'd1);
    chk("post addr",    64'(im_addr),  64'd0);
    chk("post data",    64'(wdata),    64'hCAFE_F00D);
    ld_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule : tb_cpu_boot_ctrl
`default_nettype wire

// File: doc/cpu_boot_ctrl.md
Name: cpu_boot_ctrl

Overview:
Parametrised boot/run controller for the 5-stage MIPS core, i.e. the synthesizable successor of our bench-side preload-and-run flow. It streams program and data words into instruction memory (IM) and data memory (DM) through their write ports, and holds the core in reset while loading. It then releases the core, counts cycles, and stops the core on a halt request or a programmable cycle limit. It sits between a host/loader stream and the CPU top, alongside the IF and MEM memories.

Parameters:
DATA_W, 32, memory word width
IM_DEPTH, 64, IM words (power of 2)
DM_DEPTH, 128, DM words (power of 2)
RST_CYCLES, 2, cycles core_rst held after load before run (>=1)
CNT_W, 32, cycle counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
clear  in  1  sync restart: return to LOAD, zero counters/flags
ld_valid  in  1  load beat valid
ld_ready  out  1  load beat accepted when valid&ready
ld_target  in  1  0=IM, 1=DM
ld_last  in  1  final beat of image
ld_data  in  DATA_W  word to write
start  in  1  leave LOAD without a last beat
cycle_limit  in  CNT_W  run budget; 0 = unlimited
halt_req  in  1  core end-of-program indication
im_we  out  1  IM write strobe
im_addr  out  log2(IM_DEPTH)  IM word address
dm_we  out  1  DM write strobe
dm_addr  out  log2(DM_DEPTH)  DM word address
wdata  out  DATA_W  shared write data
core_rst  out  1  active-high reset to CPU
core_en  out  1  CPU clock enable/stall release
busy  out  1  state != DONE
done  out  1  run finished
timeout  out  1  run ended by cycle_limit
ld_err  out  1  sticky: beat dropped on address overflow
cycles  out  CNT_W  cycles spent in RUN

Behaviour:
- States: LOAD, HOLD, RUN, DONE. The state register is reset asynchronously.
- Reset values: state=LOAD, im_we=dm_we=0, im_addr=dm_addr=0, wdata=0, core_rst=1, core_en=0, busy=1, done=0, timeout=0, ld_err=0, cycles=0. ld_ready=1 immediately after reset deasserts.
- ld_ready = (state==LOAD). It is combinational from state and has no dependence on ld_valid.
- LOAD: each accepted beat produces a registered write one cycle later. The strobe for ld_target is 1 for exactly one cycle, wdata=ld_data, and the address is that target's pointer.
- Per-target pointers start at 0 and increment after each write. The IM and DM pointers are independent.
- Overflow: a beat arriving when its target pointer already wrote index DEPTH-1 is accepted and dropped. No strobe is issued, ld_err is set, and the pointer does not wrap.
- LOAD -> HOLD on an accepted beat with ld_last=1 (its write still issues), or on start=1. If start and a non-last beat occur in the same cycle, the beat is written and the FSM moves to HOLD.
- HOLD: core_rst=1, core_en=0, a counter runs for RST_CYCLES cycles, then HOLD -> RUN.
- RUN: core_rst=0, core_en=1. cycles increments every RUN cycle and saturates at all-ones.
- RUN -> DONE when halt_req=1, or when cycle_limit!=0 and cycles+1==cycle_limit. If both occur in the same cycle, halt wins and timeout=0.
- DONE: core_en=0, core_rst=0 (core state preserved for inspection), done=1, busy=0. cycles is frozen. DONE is held until clear.
- clear has priority over all events in every state. On clear: state->LOAD, pointers/cycles/flags zeroed, core_rst=1, and any pending write strobe is suppressed.
- Async rst asserted mid-operation: all outputs take reset values at once, and no partial write completes.
- Write latency is 1 cycle. Throughput is one beat per cycle.

Decomposition:
- Shared package cpu_pkg: state encoding constants (ST_LOAD/ST_HOLD/ST_RUN/ST_DONE), TGT_IM/TGT_DM, and the DATA_W default.
- One sub-module, boot_addr_ctr, instantiated twice (IM and DM). It provides a parametrised depth pointer with a full flag and an overflow pulse.

Test Plan:
1. 15 IM beats (j 4 at index 9), 2 DM beats (9, 3), last on the DM beat -> im_we at addresses 0..14, dm_we at 0..1 with data 9, 3. core_rst stays high 2 cycles after the last write, then core_en=1.
2. cycle_limit=60, no halt -> done=1 and timeout=1 with cycles=60. core_en=0 from the following cycle.
3. halt_req pulsed at RUN cycle 25, cycle_limit=25 -> done=1, timeout=0, cycles=25.
4. IM_DEPTH=64, 66 IM beats -> 64 writes (addr 63 last), ld_err=1 after beat 65, no wrap to 0.
5. clear asserted in RUN at cycle 10 with a concurrent beat -> LOAD next cycle, cycles=0, core_rst=1, no write issued for that beat.
6. rst low for 12 ns mid-LOAD after 5 beats -> all outputs at reset values. After release, the next IM beat writes addr 0.
